fofb_error_integrator: RTL and testbench
========================================

Name: fofb_error_integrator

Overview:
Sequential stage that consumes the signed, saturated error samples produced by the saturating subtractor (setpoint minus readback) in the fast orbit feedback path. It accumulates the samples into a wide saturating integrator, scales the sum by a programmable arithmetic right shift, and saturates the result to the corrector command width. It emits one result per accepted error sample, with a fixed pipeline latency, and provides sticky saturation status and an accepted-sample count for monitoring.

Parameters:
EWIDTH, 16, width of signed input error sample
ACCWIDTH, 32, width of signed accumulator (must be > EWIDTH)
OWIDTH, 16, width of signed output correction
CNTWIDTH, 16, width of accepted-sample counter

Ports:
sysClk  input  1  system clock, all logic on rising edge
sysReset_n  input  1  asynchronous active-low reset
clear  input  1  synchronous clear of accumulator, status and counter
enable  input  1  1 = accept samples; 0 = ignore errValid
errValid  input  1  single-cycle strobe qualifying err
err  input  EWIDTH  signed error sample (two's complement)
shift  input  5  arithmetic right-shift applied to accumulator for output, 0..31
outValid  output  1  single-cycle strobe qualifying out
out  output  OWIDTH  signed saturated correction
accSat  output  1  sticky: accumulator clamped at least once since clear/reset
outSat  output  1  sticky: output clamped at least once since clear/reset
sampleCount  output  CNTWIDTH  accepted samples since clear/reset, wraps modulo 2^CNTWIDTH

Behaviour:
- Reset (sysReset_n low, asynchronous): accumulator, all pipeline registers, outValid, out, accSat, outSat and sampleCount = 0. Outputs stay 0 while reset is held; operation resumes on the first rising edge after deassertion.
- Accept condition: errValid & enable & ~clear in the same cycle.
- Pipeline: 3 cycles. outValid rises exactly 3 sysClk edges after the edge that samples an accepted errValid.
  - Stage 1 registers err and a valid bit.
  - Stage 2 updates the accumulator.
  - Stage 3 computes and registers out.
- Back-to-back accepted samples every cycle are supported. Each one yields one outValid.
- Accumulate:
  - Sign-extend err to ACCWIDTH+1 and add it to the sign-extended accumulator.
  - If the sum exceeds 2^(ACCWIDTH-1)-1, the accumulator becomes that maximum. If the sum is below -2^(ACCWIDTH-1), it becomes that minimum. Either clamp sets accSat.
- Output:
  - Arithmetic right shift the updated accumulator by shift, sampled in the same stage-3 cycle (floor toward -infinity, no rounding).
  - Clamp to [-2^(OWIDTH-1), 2^(OWIDTH-1)-1]. A clamp sets outSat.
  - out holds its last value between outValid strobes.
- sampleCount increments in stage 2 for each accepted sample and wraps from all-ones to 0 without flagging.
- clear (synchronous, highest priority after reset):
  - In the cycle it is high, the accumulator, all in-flight stage valid bits, accSat, outSat and sampleCount are zeroed.
  - Samples already in the pipeline are discarded, so no outValid appears for them.
  - out is also zeroed.
  - A sample presented in the same cycle as clear is not accepted.
- enable low: new samples are ignored. Samples already in flight complete normally. The accumulator holds.
- Shift changes take effect on the next computed output. The accumulator itself is never shifted.

Test Plan:
- Reset release, enable=1, shift=0, samples err=+100 ×3 back-to-back -> outValid on 3 consecutive cycles starting 3 edges after first sample, out = 100, 200, 300; sampleCount = 3.
- Sign handling: err = -5 then +2 with shift=0 -> out = -5, then -3; with shift=1 the second output is -2 (floor).
- Output saturation: OWIDTH=16, shift=0, accumulate +30000 twice -> out = 32767, outSat=1, accSat=0; then err = -32768 ×3 -> out = 32767-... wait none: accumulator 60000-98304 = -38304 -> out = -32768.
- Accumulator saturation: ACCWIDTH=32, feed err=+32767 until sum exceeds 2^31-1 -> accumulator pinned at 2147483647, accSat=1; a following err=-1 gives 2147483646.
- clear with two samples in flight -> neither produces outValid; accumulator, sticky flags, sampleCount = 0; next err=+7 -> out = 7.
- Async reset asserted mid-stream between sysClk edges -> all outputs 0 immediately. enable=0 with errValid pulses -> no outValid, sampleCount unchanged.

Source files
------------

// File: rtl/fofb_error_integrator.sv
// FOFB error integrator: 3-stage saturating accumulator with
// programmable arithmetic right shift and clamped correction output.
module fofb_error_integrator #(
  parameter int EWIDTH   = 16,
  parameter int ACCWIDTH = 32,
  parameter int OWIDTH   = 16,
  parameter int CNTWIDTH = 16
) (
  input  logic                sysClk,
  input  logic                sysReset_n,
  input  logic                clear,
  input  logic                enable,
  input  logic                errValid,
  input  logic [EWIDTH-1:0]   err,
  input  logic [4:0]          shift,
  output logic                outValid,
  output logic [OWIDTH-1:0]   out,
  output logic                accSat,
  output logic                outSat,
  output logic [CNTWIDTH-1:0] sampleCount
);

  localparam logic [ACCWIDTH-1:0] ACC_MAX =
    {1'b0, {(ACCWIDTH-1){1'b1}}};
  localparam logic [ACCWIDTH-1:0] ACC_MIN =
    {1'b1, {(ACCWIDTH-1){1'b0}}};
  localparam logic [OWIDTH-1:0] O_MAX =
    {1'b0, {(OWIDTH-1){1'b1}}};
  localparam logic [OWIDTH-1:0] O_MIN =
    {1'b1, {(OWIDTH-1){1'b0}}};

  logic                       r_s1_v;
  logic [EWIDTH-1:0]          r_s1_err;
  logic                       r_s2_v;
  logic signed [ACCWIDTH-1:0] r_acc;
  logic                       r_out_v;
  logic [OWIDTH-1:0]          r_out;
  logic                       r_acc_sat;
  logic                       r_out_sat;
  logic [CNTWIDTH-1:0]        r_cnt;

  logic                       w_accept;
  logic [ACCWIDTH:0]          w_sum;
  logic                       w_acc_ovf;
  logic [ACCWIDTH-1:0]        w_acc_next;
  logic signed [ACCWIDTH-1:0] w_shifted;
  logic [ACCWIDTH-OWIDTH:0]   w_hi;
  logic                       w_fits;
  logic [OWIDTH-1:0]          w_out_next;

  assign w_accept = errValid & enable & ~clear;

  assign w_sum =
    {r_acc[ACCWIDTH-1], r_acc} +
    {{(ACCWIDTH+1-EWIDTH){r_s1_err[EWIDTH-1]}}, r_s1_err};

  // Top two bits disagree exactly when the sum left the ACCWIDTH range.
  assign w_acc_ovf = w_sum[ACCWIDTH] ^ w_sum[ACCWIDTH-1];

  always_comb begin
    w_acc_next = w_sum[ACCWIDTH-1:0];
    if (w_acc_ovf) begin
      w_acc_next = w_sum[ACCWIDTH] ? ACC_MIN : ACC_MAX;
    end
  end

  assign w_shifted = r_acc >>> shift;
  assign w_hi      = w_shifted[ACCWIDTH-1:OWIDTH-1];
  assign w_fits    = (&w_hi) | ~(|w_hi);

  always_comb begin
    w_out_next = w_shifted[OWIDTH-1:0];
    if (!w_fits) begin
      w_out_next = w_shifted[ACCWIDTH-1] ? O_MIN : O_MAX;
    end
  end

  always_ff @(posedge sysClk or negedge sysReset_n) begin
    if (!sysReset_n) begin
      r_s1_v    <= 1'b0;
      r_s1_err  <= '0;
      r_s2_v    <= 1'b0;
      r_acc     <= '0;
      r_out_v   <= 1'b0;
      r_out     <= '0;
      r_acc_sat <= 1'b0;
      r_out_sat <= 1'b0;
      r_cnt     <= '0;
    end else if (clear) begin
      r_s1_v    <= 1'b0;
      r_s1_err  <= '0;
      r_s2_v    <= 1'b0;
      r_acc     <= '0;
      r_out_v   <= 1'b0;
      r_out     <= '0;
      r_acc_sat <= 1'b0;
      r_out_sat <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_s1_v  <= w_accept;
      r_s2_v  <= r_s1_v;
      r_out_v <= r_s2_v;
      if (w_accept) begin
        r_s1_err <= err;
      end
      if (r_s1_v) begin
        r_acc <= w_acc_next;
        r_cnt <= r_cnt + CNTWIDTH'(1);
        if (w_acc_ovf) begin
          r_acc_sat <= 1'b1;
        end
      end
      if (r_s2_v) begin
        r_out <= w_out_next;
        if (!w_fits) begin
          r_out_sat <= 1'b1;
        end
      end
    end
  end

  assign outValid    = r_out_v;
  assign out         = r_out;
  assign accSat      = r_acc_sat;
  assign outSat      = r_out_sat;
  assign sampleCount = r_cnt;

endmodule

// File: tb/tb_fofb_error_integrator.sv
// Directed bench for fofb_error_integrator: default instance plus a
// narrow-accumulator instance for cheap accumulator/counter saturation.
module tb_fofb_error_integrator;

  logic               clk;
  logic               rst_n;
  logic               clear;
  logic               enable;
  logic               errValid;
  logic signed [15:0] err;
  logic [4:0]         shift;

  logic        a_ov;
  logic [15:0] a_out;
  logic        a_asat;
  logic        a_osat;
  logic [15:0] a_cnt;

  logic        b_ov;
  logic [15:0] b_out;
  logic        b_asat;
  logic        b_osat;
  logic [3:0]  b_cnt;

  int checks;
  int failures;

  fofb_error_integrator u_a (
    .sysClk      (clk),
    .sysReset_n  (rst_n),
    .clear       (clear),
    .enable      (enable),
    .errValid    (errValid),
    .err         (err),
    .shift       (shift),
    .outValid    (a_ov),
    .out         (a_out),
    .accSat      (a_asat),
    .outSat      (a_osat),
    .sampleCount (a_cnt)
  );

  fofb_error_integrator #(
    .EWIDTH   (16),
    .ACCWIDTH (20),
    .OWIDTH   (16),
    .CNTWIDTH (4)
  ) u_b (
    .sysClk      (clk),
    .sysReset_n  (rst_n),
    .clear       (clear),
    .enable      (enable),
    .errValid    (errValid),
    .err         (err),
    .shift       (shift),
    .outValid    (b_ov),
    .out         (b_out),
    .accSat      (b_asat),
    .outSat      (b_osat),
    .sampleCount (b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic signed [63:0] obs,
                     input logic signed [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Present a sample, take one edge, land 1 time unit after it.
  task automatic cyc(input logic v, input logic signed [15:0] e);
    errValid = v;
    err      = e;
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cyc(1'b0, 16'sd0);
    clear = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    clear    = 1'b0;
    enable   = 1'b1;
    errValid = 1'b1;
    err      = 16'sd5;
    shift    = 5'd0;

    // Reset held: outputs stay 0 even with samples presented
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ov", a_ov, 0);
    chk("rst_out", $signed(a_out), 0);
    chk("rst_cnt", a_cnt, 0);
    chk("rst_osat", a_osat, 0);
    rst_n    = 1'b1;
    errValid = 1'b0;

    // +100 x3 back-to-back, latency 3 registers
    cyc(1'b1, 16'sd100);
    chk("lat_e0", a_ov, 0);
    cyc(1'b1, 16'sd100);
    chk("lat_e1", a_ov, 0);
    cyc(1'b1, 16'sd100);
    chk("b2b_v0", a_ov, 1);
    chk("b2b_o0", $signed(a_out), 100);
    cyc(1'b0, 16'sd0);
    chk("b2b_v1", a_ov, 1);
    chk("b2b_o1", $signed(a_out), 200);
    cyc(1'b0, 16'sd0);
    chk("b2b_v2", a_ov, 1);
    chk("b2b_o2", $signed(a_out), 300);
    cyc(1'b0, 16'sd0);
    chk("b2b_end", a_ov, 0);
    chk("b2b_hold", $signed(a_out), 300);
    chk("b2b_cnt", a_cnt, 3);

    // Sign handling, shift 0
    do_clear();
    chk("clr_out", $signed(a_out), 0);
    chk("clr_cnt", a_cnt, 0);
    cyc(1'b1, -16'sd5);
    cyc(1'b1, 16'sd2);
    cyc(1'b0, 16'sd0);
    chk("sgn_o0", $signed(a_out), -5);
    cyc(1'b0, 16'sd0);
    chk("sgn_o1", $signed(a_out), -3);

    // Same with shift 1: floor toward -inf
    do_clear();
    shift = 5'd1;
    cyc(1'b1, -16'sd5);
    cyc(1'b1, 16'sd2);
    cyc(1'b0, 16'sd0);
    chk("shf_o0", $signed(a_out), -3);
    cyc(1'b0, 16'sd0);
    chk("shf_o1", $signed(a_out), -2);
    shift = 5'd0;

    // Output saturation
    do_clear();
    cyc(1'b1, 16'sd30000);
    cyc(1'b1, 16'sd30000);
    cyc(1'b1, -16'sd32768);
    chk("osat_o0", $signed(a_out), 30000);
    chk("osat_f0", a_osat, 0);
    cyc(1'b1, -16'sd32768);
    chk("osat_o1", $signed(a_out), 32767);
    chk("osat_f1", a_osat, 1);
    cyc(1'b1, -16'sd32768);
    chk("osat_o2", $signed(a_out), 27232);
    cyc(1'b0, 16'sd0);
    chk("osat_o3", $signed(a_out), -5536);
    cyc(1'b0, 16'sd0);
    chk("osat_o4", $signed(a_out), -32768);
    chk("osat_asat", a_asat, 0);
    chk("osat_cnt", a_cnt, 5);

    // clear with two samples in flight, plus a sample on the clear cycle
    cyc(1'b1, 16'sd50);
    cyc(1'b1, 16'sd60);
    clear = 1'b1;
    cyc(1'b1, 16'sd99);
    clear = 1'b0;
    chk("cif_v0", a_ov, 0);
    chk("cif_out", $signed(a_out), 0);
    chk("cif_osat", a_osat, 0);
    chk("cif_cnt", a_cnt, 0);
    cyc(1'b0, 16'sd0);
    chk("cif_v1", a_ov, 0);
    cyc(1'b0, 16'sd0);
    chk("cif_v2", a_ov, 0);
    cyc(1'b0, 16'sd0);
    chk("cif_v3", a_ov, 0);
    chk("cif_cnt2", a_cnt, 0);
    cyc(1'b1, 16'sd7);
    cyc(1'b0, 16'sd0);
    cyc(1'b0, 16'sd0);
    chk("cif_v7", a_ov, 1);
    chk("cif_o7", $signed(a_out), 7);

    // In-flight sample completes after enable drops
    cyc(1'b1, 16'sd3);
    enable = 1'b0;
    cyc(1'b1, 16'sd1000);
    cyc(1'b1, 16'sd1000);
    chk("en_fl_v", a_ov, 1);
    chk("en_fl_o", $signed(a_out), 10);
    cyc(1'b1, 16'sd1000);
    chk("en_v0", a_ov, 0);
    cyc(1'b0, 16'sd0);
    chk("en_v1", a_ov, 0);
    cyc(1'b0, 16'sd0);
    chk("en_v2", a_ov, 0);
    chk("en_cnt", a_cnt, 2);
    chk("en_hold", $signed(a_out), 10);
    enable = 1'b1;

    // Accumulator saturation on the 20-bit instance
    do_clear();
    repeat (17) cyc(1'b1, 16'sd32767);
    cyc(1'b1, -16'sd1);
    repeat (15) cyc(1'b1, -16'sd32768);
    cyc(1'b0, 16'sd0);
    cyc(1'b0, 16'sd0);
    chk("asat_v", b_ov, 1);
    chk("asat_o", $signed(b_out), 32766);
    chk("asat_f", b_asat, 1);
    chk("asat_cnt", b_cnt, 1);
    chk("asat_acnt", a_cnt, 33);
    chk("asat_a_f", a_asat, 0);
    chk("asat_a_o", $signed(a_out), 32767);

    // Async reset between edges
    cyc(1'b1, 16'sd11);
    cyc(1'b1, 16'sd12);
    cyc(1'b0, 16'sd0);
    chk("ar_pre_v", a_ov, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_v", a_ov, 0);
    chk("ar_out", $signed(a_out), 0);
    chk("ar_cnt", a_cnt, 0);
    chk("ar_osat", a_osat, 0);
    chk("ar_asat", b_asat, 0);
    @(posedge clk);
    #1;
    chk("ar_hold", $signed(a_out), 0);
    rst_n = 1'b1;
    cyc(1'b1, 16'sd4);
    cyc(1'b0, 16'sd0);
    cyc(1'b0, 16'sd0);
    chk("ar_post_v", a_ov, 1);
    chk("ar_post_o", $signed(a_out), 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
